mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and data ports share one memory bus.
// Data wins ties, with a burst limit so fetches cannot starve; stalled accesses time out.
module mem_arbiter #(
  parameter int TIMEOUT  = 255,
  parameter int DM_BURST = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        err
);

  // state  | meaning
  // IDLE   | no access in flight, arbitrating incoming requests
  // IF_ACC | fetch access on the memory bus, waiting for mem_ready or timeout
  // DM_ACC | data access on the memory bus, waiting for mem_ready or timeout
  // RESP   | done (and err on timeout) pulsed to the grantee for one cycle
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] IF_ACC = 2'd1;
  localparam logic [1:0] DM_ACC = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0] state;
  logic [1:0] burst_cnt;
  logic [7:0] tmo_cnt;
  logic       grant_dm;
  logic       tmo_hit;
  logic       finish;

  // Data is preferred unless it has already taken DM_BURST grants past a waiting fetch.
  assign grant_dm = dm_req && !(if_req && (burst_cnt == 2'(DM_BURST)));
  assign tmo_hit  = (tmo_cnt == 8'(TIMEOUT - 1));
  assign finish   = mem_ready || tmo_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      burst_cnt <= 2'd0;
      tmo_cnt   <= 8'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      if_rdata  <= 32'd0;
      dm_rdata  <= 32'd0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      err       <= 1'b0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          if (!if_req) burst_cnt <= 2'd0;
          if (grant_dm) begin
            state     <= DM_ACC;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            tmo_cnt   <= 8'd0;
            if (if_req && burst_cnt != 2'd3) burst_cnt <= burst_cnt + 2'd1;
          end else if (if_req) begin
            state     <= IF_ACC;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= 32'd0;
            tmo_cnt   <= 8'd0;
            burst_cnt <= 2'd0;
          end
        end
        IF_ACC, DM_ACC: begin
          if (!mem_ready) tmo_cnt <= tmo_cnt + 8'd1;
          if (finish) begin
            // A ready on the timeout cycle still counts as a normal completion.
            mem_req <= 1'b0;
            state   <= RESP;
            err     <= !mem_ready;
            if (state == IF_ACC) begin
              if_done  <= 1'b1;
              if_rdata <= mem_ready ? mem_rdata : 32'd0;
            end else begin
              dm_done <= 1'b1;
              if (!mem_ready)   dm_rdata <= 32'd0;
              else if (!mem_we) dm_rdata <= mem_rdata;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
